// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, ALU control codes, operand/writeback
// select encodings and the decoded-control record used by ID and EX.
package rv32_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // ALU control codes, shared with the EX-stage ALU
  localparam logic [4:0] ALUC_ADD  = 5'd0;
  localparam logic [4:0] ALUC_SUB  = 5'd1;
  localparam logic [4:0] ALUC_AND  = 5'd2;
  localparam logic [4:0] ALUC_OR   = 5'd3;
  localparam logic [4:0] ALUC_XOR  = 5'd4;
  localparam logic [4:0] ALUC_SLL  = 5'd5;
  localparam logic [4:0] ALUC_SLT  = 5'd6;
  localparam logic [4:0] ALUC_SLTU = 5'd7;
  localparam logic [4:0] ALUC_SRL  = 5'd8;
  localparam logic [4:0] ALUC_SRA  = 5'd9;
  localparam logic [4:0] ALUC_JALR = 5'd10;
  localparam logic [4:0] ALUC_BEQ  = 5'd11;
  localparam logic [4:0] ALUC_BNE  = 5'd12;
  localparam logic [4:0] ALUC_BLT  = 5'd13;
  localparam logic [4:0] ALUC_BGE  = 5'd14;
  localparam logic [4:0] ALUC_BLTU = 5'd15;
  localparam logic [4:0] ALUC_BGEU = 5'd16;

  // Operand and writeback selects
  localparam logic [1:0] A_SEL_RS1   = 2'd0;
  localparam logic [1:0] A_SEL_PC    = 2'd1;
  localparam logic [1:0] A_SEL_ZERO  = 2'd2;
  localparam logic       B_SEL_RS2   = 1'b0;
  localparam logic       B_SEL_IMM   = 1'b1;
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  // Decoded control for one instruction; all-zero is the bubble encoding
  typedef struct packed {
    logic [4:0]  aluc;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } ctrl_t;

  // Register/immediate arithmetic op from funct3; alt picks SUB/SRA
  function automatic logic [4:0] alu_op_from_f3(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALUC_SUB : ALUC_ADD;
      3'b001:  op = ALUC_SLL;
      3'b010:  op = ALUC_SLT;
      3'b011:  op = ALUC_SLTU;
      3'b100:  op = ALUC_XOR;
      3'b101:  op = alt ? ALUC_SRA : ALUC_SRL;
      3'b110:  op = ALUC_OR;
      3'b111:  op = ALUC_AND;
      default: op = ALUC_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_decode.sv
// Pure combinational RV32I decoder: instruction word -> control record.
module rv32i_decode
  import rv32_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, shamt_s;
  ctrl_t       ctrl_s;
  logic        illegal_s;

  assign opcode_s = instr_i[6:0];
  assign f3_s     = instr_i[14:12];
  assign f7_s     = instr_i[31:25];
  assign imm_i_s  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_s  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u_s  = {instr_i[31:12], 12'h000};
  assign imm_j_s  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign shamt_s  = {27'd0, instr_i[24:20]};

  // Per-opcode field decode; unused register fields stay zero
  always_comb begin
    ctrl_s    = '0;
    illegal_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        illegal_s = !((f7_s == 7'b0000000) ||
                      ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))));
        ctrl_s.aluc      = alu_op_from_f3(f3_s, f7_s[5]);
        ctrl_s.rs1       = instr_i[19:15];
        ctrl_s.rs2       = instr_i[24:20];
        ctrl_s.rd        = instr_i[11:7];
        ctrl_s.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_s.b_sel     = B_SEL_IMM;
        ctrl_s.rs1       = instr_i[19:15];
        ctrl_s.rd        = instr_i[11:7];
        ctrl_s.reg_write = 1'b1;
        case (f3_s)
          3'b001: begin
            illegal_s   = (f7_s != 7'b0000000);
            ctrl_s.aluc = ALUC_SLL;
            ctrl_s.imm  = shamt_s;
          end
          3'b101: begin
            illegal_s   = (f7_s != 7'b0000000) && (f7_s != 7'b0100000);
            ctrl_s.aluc = alu_op_from_f3(f3_s, f7_s[5]);
            ctrl_s.imm  = shamt_s;
          end
          default: begin
            ctrl_s.aluc = alu_op_from_f3(f3_s, 1'b0);
            ctrl_s.imm  = imm_i_s;
          end
        endcase
      end
      OPC_LUI: begin
        ctrl_s.a_sel     = A_SEL_ZERO;
        ctrl_s.b_sel     = B_SEL_IMM;
        ctrl_s.imm       = imm_u_s;
        ctrl_s.rd        = instr_i[11:7];
        ctrl_s.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_s.a_sel     = A_SEL_PC;
        ctrl_s.b_sel     = B_SEL_IMM;
        ctrl_s.imm       = imm_u_s;
        ctrl_s.rd        = instr_i[11:7];
        ctrl_s.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        case (f3_s)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_s = 1'b0;
          default:                                illegal_s = 1'b1;
        endcase
        ctrl_s.b_sel      = B_SEL_IMM;
        ctrl_s.imm        = imm_i_s;
        ctrl_s.rs1        = instr_i[19:15];
        ctrl_s.rd         = instr_i[11:7];
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.wb_sel     = WB_SEL_MEM;
        ctrl_s.mem_read   = 1'b1;
        ctrl_s.mem_funct3 = f3_s;
      end
      OPC_STORE: begin
        case (f3_s)
          3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
          default:                illegal_s = 1'b1;
        endcase
        ctrl_s.b_sel      = B_SEL_IMM;
        ctrl_s.imm        = imm_s_s;
        ctrl_s.rs1        = instr_i[19:15];
        ctrl_s.rs2        = instr_i[24:20];
        ctrl_s.mem_write  = 1'b1;
        ctrl_s.mem_funct3 = f3_s;
      end
      OPC_BRANCH: begin
        case (f3_s)
          3'b000:  ctrl_s.aluc = ALUC_BEQ;
          3'b001:  ctrl_s.aluc = ALUC_BNE;
          3'b100:  ctrl_s.aluc = ALUC_BLT;
          3'b101:  ctrl_s.aluc = ALUC_BGE;
          3'b110:  ctrl_s.aluc = ALUC_BLTU;
          3'b111:  ctrl_s.aluc = ALUC_BGEU;
          default: illegal_s   = 1'b1;
        endcase
        ctrl_s.imm       = imm_b_s;
        ctrl_s.rs1       = instr_i[19:15];
        ctrl_s.rs2       = instr_i[24:20];
        ctrl_s.is_branch = 1'b1;
      end
      OPC_JAL: begin
        ctrl_s.a_sel     = A_SEL_PC;
        ctrl_s.b_sel     = B_SEL_IMM;
        ctrl_s.imm       = imm_j_s;
        ctrl_s.rd        = instr_i[11:7];
        ctrl_s.reg_write = 1'b1;
        ctrl_s.wb_sel    = WB_SEL_PC4;
        ctrl_s.is_jump   = 1'b1;
      end
      OPC_JALR: begin
        illegal_s        = (f3_s != 3'b000);
        ctrl_s.aluc      = ALUC_JALR;
        ctrl_s.b_sel     = B_SEL_IMM;
        ctrl_s.imm       = imm_i_s;
        ctrl_s.rs1       = instr_i[19:15];
        ctrl_s.rd        = instr_i[11:7];
        ctrl_s.reg_write = 1'b1;
        ctrl_s.wb_sel    = WB_SEL_PC4;
        ctrl_s.is_jump   = 1'b1;
      end
      OPC_MISC_MEM: illegal_s = (f3_s != 3'b000);
      OPC_SYSTEM:   illegal_s = (f3_s != 3'b000);
      default:      illegal_s = 1'b1;
    endcase
  end

  // Collapse illegal encodings to a flagged NOP; never write x0
  always_comb begin
    ctrl_o = ctrl_s;
    if (illegal_s || (instr_i[1:0] != 2'b11)) begin
      ctrl_o         = '0;
      ctrl_o.illegal = 1'b1;
    end else begin
      ctrl_o.reg_write = ctrl_s.reg_write & (ctrl_s.rd != 5'd0);
    end
  end

endmodule

// File: rtl/id_ex_decode_stage.sv
// ID stage: RV32I decode plus the ID/EX pipeline register with stall/flush.
module id_ex_decode_stage
  import rv32_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [4:0]      ex_aluc,
  output logic [1:0]      ex_a_sel,
  output logic            ex_b_sel,
  output logic [31:0]     ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic [1:0]      ex_wb_sel,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [2:0]      ex_mem_funct3,
  output logic            ex_is_branch,
  output logic            ex_is_jump,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);

  ctrl_t           dec_s;
  ctrl_t           ctrl_d, ctrl_q;
  logic            valid_d, valid_q;
  logic [XLEN-1:0] pc_d, pc_q;

  rv32i_decode u_decode (
    .instr_i (id_instr),
    .ctrl_o  (dec_s)
  );

  // Next ID/EX contents: flush beats stall beats load; a bubble keeps the PC
  always_comb begin
    if (flush) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      pc_d    = pc_q;
    end else if (stall) begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
      pc_d    = pc_q;
    end else if (id_valid) begin
      ctrl_d  = dec_s;
      valid_d = 1'b1;
      pc_d    = id_pc;
    end else begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      pc_d    = pc_q;
    end
  end

  // ID/EX register; reset dominates every other control
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_aluc       = ctrl_q.aluc;
  assign ex_a_sel      = ctrl_q.a_sel;
  assign ex_b_sel      = ctrl_q.b_sel;
  assign ex_imm        = ctrl_q.imm;
  assign ex_rs1        = ctrl_q.rs1;
  assign ex_rs2        = ctrl_q.rs2;
  assign ex_rd         = ctrl_q.rd;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_wb_sel     = ctrl_q.wb_sel;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_funct3 = ctrl_q.mem_funct3;
  assign ex_is_branch  = ctrl_q.is_branch;
  assign ex_is_jump    = ctrl_q.is_jump;
  assign ex_illegal    = ctrl_q.illegal;
  assign ex_pc         = pc_q;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Scoreboard bench for id_ex_decode_stage: stimulus pushes the expected
// ID/EX contents after each edge, a monitor pops and compares on negedge.
module tb_id_ex_decode_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_instr, id_pc;
  logic        ex_valid, ex_b_sel, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_is_branch, ex_is_jump, ex_illegal;
  logic [4:0]  ex_aluc, ex_rs1, ex_rs2, ex_rd;
  logic [1:0]  ex_a_sel, ex_wb_sel;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_imm, ex_pc;

  id_ex_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_aluc(ex_aluc),
    .ex_a_sel(ex_a_sel), .ex_b_sel(ex_b_sel), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_wb_sel(ex_wb_sel),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_funct3(ex_mem_funct3),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        valid, illegal, b_sel, reg_write, mem_read, mem_write, is_branch, is_jump;
    logic [4:0]  aluc, rs1, rs2, rd;
    logic [1:0]  a_sel, wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] imm, pc;
    logic        chk_pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic exp_t bubble(int id, logic [31:0] pc, logic chk_pc);
    exp_t e;
    e.id = id; e.valid = 1'b0; e.illegal = 1'b0; e.b_sel = 1'b0; e.reg_write = 1'b0;
    e.mem_read = 1'b0; e.mem_write = 1'b0; e.is_branch = 1'b0; e.is_jump = 1'b0;
    e.aluc = 5'd0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.rd = 5'd0; e.a_sel = 2'd0; e.wb_sel = 2'd0;
    e.mem_funct3 = 3'd0; e.imm = 32'd0; e.pc = pc; e.chk_pc = chk_pc;
    return e;
  endfunction

  task automatic chk(int id, string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.id, "valid",      32'(ex_valid),      32'(e.valid));
        chk(e.id, "illegal",    32'(ex_illegal),    32'(e.illegal));
        chk(e.id, "aluc",       32'(ex_aluc),       32'(e.aluc));
        chk(e.id, "a_sel",      32'(ex_a_sel),      32'(e.a_sel));
        chk(e.id, "b_sel",      32'(ex_b_sel),      32'(e.b_sel));
        chk(e.id, "imm",        ex_imm,             e.imm);
        chk(e.id, "rs1",        32'(ex_rs1),        32'(e.rs1));
        chk(e.id, "rs2",        32'(ex_rs2),        32'(e.rs2));
        chk(e.id, "rd",         32'(ex_rd),         32'(e.rd));
        chk(e.id, "reg_write",  32'(ex_reg_write),  32'(e.reg_write));
        chk(e.id, "wb_sel",     32'(ex_wb_sel),     32'(e.wb_sel));
        chk(e.id, "mem_read",   32'(ex_mem_read),   32'(e.mem_read));
        chk(e.id, "mem_write",  32'(ex_mem_write),  32'(e.mem_write));
        chk(e.id, "mem_funct3", 32'(ex_mem_funct3), 32'(e.mem_funct3));
        chk(e.id, "is_branch",  32'(ex_is_branch),  32'(e.is_branch));
        chk(e.id, "is_jump",    32'(ex_is_jump),    32'(e.is_jump));
        if (e.chk_pc) chk(e.id, "pc", ex_pc, e.pc);
      end
    end
  end

  // Drive one cycle of inputs, then queue what ID/EX must hold after the edge
  task automatic apply(logic r, logic v, logic s, logic f, logic [31:0] ins,
                       logic [31:0] pc, exp_t e);
    rst = r; id_valid = v; stall = s; flush = f; id_instr = ins; id_pc = pc;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e, held;
    rst = 1'b1; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    id_instr = 32'h0000_0013; id_pc = 32'd0;

    // 0: reset state
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'h0, bubble(0, RST_PC, 1'b1));
    apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0, bubble(0, RST_PC, 1'b1));

    // 1: ADD x3,x1,x2
    e = bubble(1, 32'h200, 1'b1); e.valid = 1'b1;
    e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = 5'd3; e.reg_write = 1'b1;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0020_81B3, 32'h200, e);

    // 2: SRAI x5,x6,3
    e = bubble(2, 32'h204, 1'b1); e.valid = 1'b1; e.aluc = 5'd9; e.b_sel = 1'b1;
    e.imm = 32'h3; e.rs1 = 5'd6; e.rd = 5'd5; e.reg_write = 1'b1;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h4033_5293, 32'h204, e);

    // 3: BGE x1,x2,-8
    e = bubble(3, 32'h208, 1'b1); e.valid = 1'b1; e.aluc = 5'd14; e.imm = 32'hFFFF_FFF8;
    e.rs1 = 5'd1; e.rs2 = 5'd2; e.is_branch = 1'b1;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'hFE20_DCE3, 32'h208, e);

    // 4: JALR x1,0(x5), then two stall cycles, then flush+stall
    e = bubble(4, 32'h20C, 1'b1); e.valid = 1'b1; e.aluc = 5'd10; e.b_sel = 1'b1;
    e.rs1 = 5'd5; e.rd = 5'd1; e.reg_write = 1'b1; e.wb_sel = 2'd2; e.is_jump = 1'b1;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0002_80E7, 32'h20C, e);
    held = e; held.id = 40;
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0020_81B3, 32'h300, held);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0020_81B3, 32'h304, held);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h0020_81B3, 32'h308, bubble(41, 32'h20C, 1'b1));

    // 5: all-ones word is illegal; ADDI x0,x0,1 never writes
    e = bubble(5, 32'h210, 1'b1); e.valid = 1'b1; e.illegal = 1'b1;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h210, e);
    e = bubble(51, 32'h214, 1'b1); e.valid = 1'b1; e.b_sel = 1'b1; e.imm = 32'h1;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0010_0013, 32'h214, e);

    // LW x7,-4(x2)
    e = bubble(52, 32'h218, 1'b1); e.valid = 1'b1; e.b_sel = 1'b1; e.imm = 32'hFFFF_FFFC;
    e.rs1 = 5'd2; e.rd = 5'd7; e.reg_write = 1'b1; e.wb_sel = 2'd1; e.mem_read = 1'b1;
    e.mem_funct3 = 3'd2;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFC1_2383, 32'h218, e);

    // SW x5,8(x1)
    e = bubble(53, 32'h21C, 1'b1); e.valid = 1'b1; e.b_sel = 1'b1; e.imm = 32'h8;
    e.rs1 = 5'd1; e.rs2 = 5'd5; e.mem_write = 1'b1; e.mem_funct3 = 3'd2;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0050_A423, 32'h21C, e);

    // LUI x4,0x12345
    e = bubble(54, 32'h220, 1'b1); e.valid = 1'b1; e.a_sel = 2'd2; e.b_sel = 1'b1;
    e.imm = 32'h1234_5000; e.rd = 5'd4; e.reg_write = 1'b1;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5237, 32'h220, e);

    // id_valid=0 loads a bubble
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0020_81B3, 32'h224, bubble(55, 32'h0, 1'b0));

    // bad funct7 on OP, and a compressed-quadrant word
    e = bubble(56, 32'h228, 1'b1); e.valid = 1'b1; e.illegal = 1'b1;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0220_81B3, 32'h228, e);
    e = bubble(57, 32'h22C, 1'b1); e.valid = 1'b1; e.illegal = 1'b1;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0020_81B0, 32'h22C, e);

    // 6: reset during a valid, stalled load, then release with id_valid=0
    apply(1'b1, 1'b1, 1'b1, 1'b0, 32'h0020_81B3, 32'h230, bubble(6, RST_PC, 1'b1));
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0020_81B3, 32'h234, bubble(61, 32'h0, 1'b0));

    repeat (3) @(negedge clk);
    chk(99, "queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
